gcd_ctrl: RTL

Euclidean GCD controller that acts as the requesting side of the `run`/`ready` modulo-engine interface. It accepts an operand pair on a valid/ready input port and issues a sequence of `A mod B` calls to an external modulo engine. After each call it rotates the operands (a←b, b←remainder) and returns the GCD plus an iteration count on a valid/ready output port. It sits between the command source and the modulo engine inside the GCD top level.

---
 rtl/gcd_pkg.sv | 21 ++
 rtl/gcd_timeout.sv | 24 ++
 rtl/gcd_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// Shared types and defaults for the Euclidean GCD controller.
package gcd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WAIT,
    S_GAP,
    S_DONE
  } gcd_state_e;

  localparam int GCD_W       = 31;
  localparam int GCD_ITER_W  = 6;
  localparam int GCD_TIMEOUT = 4096;

  // Engine ports are 32 bits wide; operands never exceed 31 bits.
  function automatic logic [31:0] widen32(input logic [30:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/gcd_timeout.sv
// Per-call watchdog: counts enabled cycles since the last clear, flags expiry.
module gcd_timeout #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) cnt <= '0;
    else if (en)      cnt <= cnt + CW'(1);
  end

  // Fires on the last allowed cycle so the caller sees exactly TIMEOUT enabled cycles.
  assign expire = en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/gcd_ctrl.sv
// Euclidean GCD controller driving an external run/ready modulo engine.
// Optional per-call watchdog enabled by defining GCD_TIMEOUT_EN.
module gcd_ctrl
  import gcd_pkg::*;
#(
  parameter int W       = GCD_W,
  parameter int ITER_W  = GCD_ITER_W,
  parameter int TIMEOUT = GCD_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_a,
  input  logic [W-1:0]      in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_gcd,
  output logic [ITER_W-1:0] out_iter,
  output logic              out_err,
  output logic              mod_run,
  output logic [31:0]       mod_a,
  output logic [31:0]       mod_b,
  input  logic [31:0]       mod_result,
  input  logic              mod_ready
);

  if (W > 31 || W < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("gcd_ctrl: W must be 1..31 and TIMEOUT >= 1");
  end

  gcd_state_e state, state_nx;

  logic [W-1:0]      a, b, gcd_q;
  logic [ITER_W-1:0] iter;
  logic              tmo;

  // Remainder is always < divisor < 2^W, so the upper engine bits carry nothing.
  logic unused_mod;
  assign unused_mod = ^mod_result[31:W];

`ifdef GCD_TIMEOUT_EN
  logic err_q;

  gcd_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clr    (state != S_WAIT),
    .en     (state == S_WAIT),
    .expire (tmo)
  );

  always_ff @(posedge clk) begin
    if (reset)                                      err_q <= 1'b0;
    else if (state == S_IDLE && in_valid)           err_q <= 1'b0;
    else if (state == S_WAIT && !mod_ready && tmo)  err_q <= 1'b1;
  end

  assign out_err = err_q;
`else
  assign tmo     = 1'b0;
  assign out_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      a     <= '0;
      b     <= '0;
      gcd_q <= '0;
      iter  <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        S_IDLE: if (in_valid) begin
          a    <= in_a;
          b    <= in_b;
          iter <= '0;
        end
        S_CHECK: if (b == '0) gcd_q <= a;
        S_WAIT: begin
          if (mod_ready) begin
            a    <= b;
            b    <= mod_result[W-1:0];
            iter <= iter + ITER_W'(1);
          end else if (tmo) begin
            gcd_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (in_valid) state_nx = S_CHECK;
      S_CHECK: state_nx = (b == '0) ? S_DONE : S_WAIT;
      S_WAIT: begin
        if (mod_ready) state_nx = S_GAP;
        else if (tmo)  state_nx = S_DONE;
      end
      S_GAP:   state_nx = S_CHECK;
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign mod_run   = (state == S_WAIT);
  assign out_gcd   = gcd_q;
  assign out_iter  = iter;
  assign mod_a     = widen32(31'(a));
  assign mod_b     = widen32(31'(b));

endmodule
